// File: rtl/ex_mem_lsu_if.sv
// SRAM bus bundle between the EX/MEM load/store sequencer (master) and
// the external base SRAM pads (slave). All strobes are active-low.
interface ex_mem_lsu_if #(
  parameter int ADDR_W = 20
);
  logic [ADDR_W-1:0] sram_addr_o;
  logic [31:0]       sram_data_o;
  logic [31:0]       sram_data_i;
  logic              sram_drive_o;
  logic [3:0]        sram_be_n_o;
  logic              sram_ce_n_o;
  logic              sram_oe_n_o;
  logic              sram_we_n_o;

  modport master (
    output sram_addr_o, sram_data_o, sram_drive_o, sram_be_n_o,
    output sram_ce_n_o, sram_oe_n_o, sram_we_n_o,
    input  sram_data_i
  );

  modport slave (
    input  sram_addr_o, sram_data_o, sram_drive_o, sram_be_n_o,
    input  sram_ce_n_o, sram_oe_n_o, sram_we_n_o,
    output sram_data_i
  );
endinterface

// File: rtl/ex_mem_lsu.sv
// EX/MEM pipeline register fused with a multi-cycle SRAM load/store
// sequencer. The pipeline is held (stall_req_o) while an access is in
// flight; loads return aligned, extended data on wdata_o.
// Optional macro LSU_MISALIGN_EXC_EN: misaligned LW/SW/LH/LHU/SH skip the
// SRAM, suppress the register write and report misalign_o/badvaddr_o.
module ex_mem_lsu #(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [4:0]  ex_wd_i,
  input  logic        ex_wreg_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [3:0]  ex_memop_i,
  input  logic [31:0] ex_mem_addr_i,
  input  logic [31:0] ex_mem_wdata_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stall_req_o,
  ex_mem_lsu_if.master sram
`ifdef LSU_MISALIGN_EXC_EN
  ,
  output logic        misalign_o,
  output logic [31:0] badvaddr_o
`endif
);

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_LH   = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;

  state_e      r_state;
  logic [3:0]  r_op;
  logic [3:0]  r_cnt;
  logic [4:0]  r_wd;
  logic        r_wreg;
  logic [31:0] r_wdata;
  logic [31:0] r_addr;
  logic [31:0] r_sdata;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_busy;
  logic [3:0]  w_op_in;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [3:0]  w_be_n;
  logic [31:0] w_sdata_rep;
  logic        w_unused_addr;

  // Only the word address reaches the SRAM; upper byte-address bits are dropped.
  assign w_unused_addr = ^r_addr[31:ADDR_W+2];

  // Unknown op encodings are normalised to NONE at capture.
  assign w_op_in    = (ex_memop_i > OP_SW) ? OP_NONE : ex_memop_i;
  assign w_is_load  = (r_op >= OP_LB) && (r_op <= OP_LW);
  assign w_is_store = (r_op >= OP_SB) && (r_op <= OP_SW);
  assign w_busy     = ((r_state == ST_IDLE) && (w_is_load || w_is_store)) ||
                      (r_state == ST_ACCESS);

  assign wd_o        = r_wd;
  assign wreg_o      = r_wreg;
  assign wdata_o     = r_wdata;
  assign stall_req_o = w_busy;

  // Strobes and bus are decoded from registered state only, so they glitch-free
  // follow reset and flush.
  assign sram.sram_ce_n_o  = ~w_busy;
  assign sram.sram_oe_n_o  = ~((r_state == ST_ACCESS) && w_is_load);
  assign sram.sram_we_n_o  = ~((r_state == ST_ACCESS) && w_is_store);
  assign sram.sram_drive_o = w_busy && w_is_store;
  assign sram.sram_addr_o  = w_busy ? r_addr[ADDR_W+1:2] : '0;
  assign sram.sram_be_n_o  = w_busy ? w_be_n : 4'hF;
  assign sram.sram_data_o  = (w_busy && w_is_store) ? w_sdata_rep : 32'h0;

  // Little-endian lane selection and sign/zero extension of returning load data.
  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = sram.sram_data_i[7:0];
      2'd1:    w_byte = sram.sram_data_i[15:8];
      2'd2:    w_byte = sram.sram_data_i[23:16];
      default: w_byte = sram.sram_data_i[31:24];
    endcase
    w_half = r_addr[1] ? sram.sram_data_i[31:16] : sram.sram_data_i[15:0];
    case (r_op)
      OP_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_load_data = {24'h0, w_byte};
      OP_LH:   w_load_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_load_data = {16'h0, w_half};
      default: w_load_data = sram.sram_data_i;
    endcase
  end

  // Byte-lane enables and replicated store data; loads enable every lane.
  always_comb begin
    case (r_op)
      OP_SB: begin
        w_be_n      = ~(4'b0001 << r_addr[1:0]);
        w_sdata_rep = {4{r_sdata[7:0]}};
      end
      OP_SH: begin
        w_be_n      = r_addr[1] ? 4'b0011 : 4'b1100;
        w_sdata_rep = {2{r_sdata[15:0]}};
      end
      default: begin
        w_be_n      = 4'b0000;
        w_sdata_rep = r_sdata;
      end
    endcase
  end

`ifdef LSU_MISALIGN_EXC_EN
  logic        r_misalign;
  logic [31:0] r_badvaddr;
  logic        w_misalign;

  assign misalign_o = r_misalign;
  assign badvaddr_o = r_badvaddr;

  // Word ops need addr[1:0]==0, halfword ops need addr[0]==0.
  always_comb begin
    w_misalign = 1'b0;
    case (w_op_in)
      OP_LW, OP_SW:         w_misalign = |ex_mem_addr_i[1:0];
      OP_LH, OP_LHU, OP_SH: w_misalign = ex_mem_addr_i[0];
      default:              w_misalign = 1'b0;
    endcase
  end
`endif

  // Pipeline capture (flush > hold > load) and the access sequencer.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_op    <= OP_NONE;
      r_cnt   <= 4'd0;
      r_wd    <= 5'd0;
      r_wreg  <= 1'b0;
      r_wdata <= 32'h0;
      r_addr  <= 32'h0;
      r_sdata <= 32'h0;
`ifdef LSU_MISALIGN_EXC_EN
      r_misalign <= 1'b0;
      r_badvaddr <= 32'h0;
`endif
    end else begin
`ifdef LSU_MISALIGN_EXC_EN
      r_misalign <= 1'b0;
`endif
      if (flush_i) begin
        r_state <= ST_IDLE;
        r_op    <= OP_NONE;
        r_wd    <= 5'd0;
        r_wreg  <= 1'b0;
        r_wdata <= 32'h0;
      end else if (w_busy || stall_i) begin
        // Pipeline registers hold; the sequencer keeps running.
        case (r_state)
          ST_IDLE: begin
            if (w_busy) begin
              r_state <= ST_ACCESS;
              r_cnt   <= CNT_INIT;
            end
          end
          ST_ACCESS: begin
            if (r_cnt == 4'd0) begin
              r_state <= ST_DONE;
              if (w_is_load) r_wdata <= w_load_data;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
          default: r_state <= r_state;
        endcase
      end else begin
        r_state <= ST_IDLE;
        r_op    <= w_op_in;
        r_wd    <= ex_wd_i;
        r_wreg  <= ex_wreg_i;
        r_wdata <= ex_wdata_i;
        r_addr  <= ex_mem_addr_i;
        r_sdata <= ex_mem_wdata_i;
`ifdef LSU_MISALIGN_EXC_EN
        if (w_misalign) begin
          r_op       <= OP_NONE;
          r_wreg     <= 1'b0;
          r_misalign <= 1'b1;
          r_badvaddr <= ex_mem_addr_i;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_lsu.sv
// Directed testbench for ex_mem_lsu: reset, ALU pass-through, loads,
// stores, stall/flush in DONE, back-to-back capture, async reset mid-access.
module tb_ex_mem_lsu;
  localparam int ADDR_W      = 20;
  localparam int WAIT_CYCLES = 1;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [4:0]  ex_wd_i = '0;
  logic        ex_wreg_i = 1'b0;
  logic [31:0] ex_wdata_i = '0;
  logic [3:0]  ex_memop_i = '0;
  logic [31:0] ex_mem_addr_i = '0;
  logic [31:0] ex_mem_wdata_i = '0;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_req_o;
`ifdef LSU_MISALIGN_EXC_EN
  logic        misalign_o;
  logic [31:0] badvaddr_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  ex_mem_lsu_if #(.ADDR_W(ADDR_W)) sram_bus ();

  ex_mem_lsu #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .ex_wd_i        (ex_wd_i),
    .ex_wreg_i      (ex_wreg_i),
    .ex_wdata_i     (ex_wdata_i),
    .ex_memop_i     (ex_memop_i),
    .ex_mem_addr_i  (ex_mem_addr_i),
    .ex_mem_wdata_i (ex_mem_wdata_i),
    .wd_o           (wd_o),
    .wreg_o         (wreg_o),
    .wdata_o        (wdata_o),
    .stall_req_o    (stall_req_o),
    .sram           (sram_bus)
`ifdef LSU_MISALIGN_EXC_EN
    ,
    .misalign_o     (misalign_o),
    .badvaddr_o     (badvaddr_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_ex(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] wdata, input logic [31:0] addr,
                        input logic [31:0] sdata);
    ex_memop_i     = op;
    ex_wd_i        = wd;
    ex_wreg_i      = wreg;
    ex_wdata_i     = wdata;
    ex_mem_addr_i  = addr;
    ex_mem_wdata_i = sdata;
  endtask

  task automatic check_idle_outputs(input string name);
    n_cmp++; if (wd_o !== 5'd0) begin n_err++; $display("FAIL %s wd_o: got %h want 00", name, wd_o); end
    n_cmp++; if (wreg_o !== 1'b0) begin n_err++; $display("FAIL %s wreg_o: got %b want 0", name, wreg_o); end
    n_cmp++; if (wdata_o !== 32'h0) begin n_err++; $display("FAIL %s wdata_o: got %h want 0", name, wdata_o); end
    n_cmp++; if (stall_req_o !== 1'b0) begin n_err++; $display("FAIL %s stall_req_o: got %b want 0", name, stall_req_o); end
    n_cmp++; if ({sram_bus.sram_ce_n_o, sram_bus.sram_oe_n_o, sram_bus.sram_we_n_o} !== 3'b111) begin
      n_err++; $display("FAIL %s ce/oe/we_n: got %b want 111", name,
                        {sram_bus.sram_ce_n_o, sram_bus.sram_oe_n_o, sram_bus.sram_we_n_o}); end
    n_cmp++; if (sram_bus.sram_be_n_o !== 4'hF) begin n_err++; $display("FAIL %s be_n: got %b want 1111", name, sram_bus.sram_be_n_o); end
    n_cmp++; if (sram_bus.sram_drive_o !== 1'b0) begin n_err++; $display("FAIL %s drive: got %b want 0", name, sram_bus.sram_drive_o); end
    n_cmp++; if (sram_bus.sram_addr_o !== 20'h0) begin n_err++; $display("FAIL %s sram_addr: got %h want 0", name, sram_bus.sram_addr_o); end
    n_cmp++; if (sram_bus.sram_data_o !== 32'h0) begin n_err++; $display("FAIL %s sram_data: got %h want 0", name, sram_bus.sram_data_o); end
  endtask

  task automatic test_reset;
    #3;
    check_idle_outputs("reset");
    @(negedge clk_i);
    rst_i = 1'b1;
    step;
    $display("reset: released");
  endtask

  task automatic test_alu;
    set_ex(4'd0, 5'd5, 1'b1, 32'h0000_1234, 32'h0, 32'h0);
    step;
    set_ex(4'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    n_cmp++; if (wd_o !== 5'd5) begin n_err++; $display("FAIL alu wd_o: got %0d want 5", wd_o); end
    n_cmp++; if (wreg_o !== 1'b1) begin n_err++; $display("FAIL alu wreg_o: got %b want 1", wreg_o); end
    n_cmp++; if (wdata_o !== 32'h1234) begin n_err++; $display("FAIL alu wdata_o: got %h want 00001234", wdata_o); end
    n_cmp++; if (stall_req_o !== 1'b0) begin n_err++; $display("FAIL alu stall_req_o: got %b want 0", stall_req_o); end
    n_cmp++; if (sram_bus.sram_ce_n_o !== 1'b1) begin n_err++; $display("FAIL alu ce_n: got %b want 1", sram_bus.sram_ce_n_o); end
    $display("alu: wd=%0d wreg=%b wdata=%h", wd_o, wreg_o, wdata_o);
    step;
  endtask

  task automatic test_load(input string name, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] word, input logic [19:0] exp_waddr,
                           input logic [31:0] exp_data);
    int n_stall;
    int n_oe;
    int guard;
    set_ex(op, 5'd7, 1'b1, 32'h1111_2222, addr, 32'h0);
    sram_bus.sram_data_i = word;
    step;
    set_ex(4'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    n_cmp++; if (sram_bus.sram_addr_o !== exp_waddr) begin n_err++; $display("FAIL %s sram_addr: got %h want %h", name, sram_bus.sram_addr_o, exp_waddr); end
    n_cmp++; if (sram_bus.sram_be_n_o !== 4'b0000) begin n_err++; $display("FAIL %s be_n: got %b want 0000", name, sram_bus.sram_be_n_o); end
    n_cmp++; if (sram_bus.sram_ce_n_o !== 1'b0) begin n_err++; $display("FAIL %s ce_n: got %b want 0", name, sram_bus.sram_ce_n_o); end
    n_stall = 0; n_oe = 0; guard = 0;
    while (stall_req_o === 1'b1 && guard < 40) begin
      n_stall++;
      if (sram_bus.sram_oe_n_o === 1'b0) n_oe++;
      step;
      guard++;
    end
    n_cmp++; if (n_stall != WAIT_CYCLES + 1) begin n_err++; $display("FAIL %s stall cycles: got %0d want %0d", name, n_stall, WAIT_CYCLES + 1); end
    n_cmp++; if (n_oe != WAIT_CYCLES) begin n_err++; $display("FAIL %s oe_n low cycles: got %0d want %0d", name, n_oe, WAIT_CYCLES); end
    n_cmp++; if (wdata_o !== exp_data) begin n_err++; $display("FAIL %s wdata_o: got %h want %h", name, wdata_o, exp_data); end
    n_cmp++; if ({wd_o, wreg_o} !== {5'd7, 1'b1}) begin n_err++; $display("FAIL %s wd/wreg: got %0d/%b want 7/1", name, wd_o, wreg_o); end
    n_cmp++; if (sram_bus.sram_ce_n_o !== 1'b1) begin n_err++; $display("FAIL %s done ce_n: got %b want 1", name, sram_bus.sram_ce_n_o); end
    $display("%s: addr=%h word=%h -> wdata=%h stall=%0d", name, addr, word, wdata_o, n_stall);
    step;
  endtask

  task automatic test_store(input string name, input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] sdata, input logic [19:0] exp_waddr,
                            input logic [31:0] exp_bus, input logic [3:0] exp_be_n);
    int n_stall;
    int n_we;
    int guard;
    set_ex(op, 5'd0, 1'b0, 32'h0, addr, sdata);
    step;
    set_ex(4'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    n_cmp++; if (sram_bus.sram_addr_o !== exp_waddr) begin n_err++; $display("FAIL %s sram_addr: got %h want %h", name, sram_bus.sram_addr_o, exp_waddr); end
    n_cmp++; if (sram_bus.sram_data_o !== exp_bus) begin n_err++; $display("FAIL %s sram_data: got %h want %h", name, sram_bus.sram_data_o, exp_bus); end
    n_cmp++; if (sram_bus.sram_be_n_o !== exp_be_n) begin n_err++; $display("FAIL %s be_n: got %b want %b", name, sram_bus.sram_be_n_o, exp_be_n); end
    n_cmp++; if (sram_bus.sram_drive_o !== 1'b1) begin n_err++; $display("FAIL %s drive: got %b want 1", name, sram_bus.sram_drive_o); end
    n_cmp++; if (sram_bus.sram_we_n_o !== 1'b1) begin n_err++; $display("FAIL %s setup we_n: got %b want 1", name, sram_bus.sram_we_n_o); end
    n_stall = 0; n_we = 0; guard = 0;
    while (stall_req_o === 1'b1 && guard < 40) begin
      n_stall++;
      if (sram_bus.sram_we_n_o === 1'b0) n_we++;
      step;
      guard++;
    end
    n_cmp++; if (n_stall != WAIT_CYCLES + 1) begin n_err++; $display("FAIL %s stall cycles: got %0d want %0d", name, n_stall, WAIT_CYCLES + 1); end
    n_cmp++; if (n_we != WAIT_CYCLES) begin n_err++; $display("FAIL %s we_n low cycles: got %0d want %0d", name, n_we, WAIT_CYCLES); end
    n_cmp++; if (sram_bus.sram_drive_o !== 1'b0) begin n_err++; $display("FAIL %s done drive: got %b want 0", name, sram_bus.sram_drive_o); end
    $display("%s: addr=%h data=%h -> bus=%h be_n=%b", name, addr, sdata, exp_bus, exp_be_n);
    step;
  endtask

  task automatic test_stall_done;
    int guard;
    set_ex(4'd5, 5'd3, 1'b1, 32'h0, 32'h0000_0010, 32'h0);
    sram_bus.sram_data_i = 32'hCAFE_F00D;
    step;
    stall_i = 1'b1;
    set_ex(4'd0, 5'd9, 1'b1, 32'h0000_5555, 32'h0, 32'h0);
    guard = 0;
    while (stall_req_o === 1'b1 && guard < 40) begin step; guard++; end
    for (int i = 0; i < 3; i++) begin
      step;
      n_cmp++; if (wdata_o !== 32'hCAFE_F00D) begin n_err++; $display("FAIL stall_done wdata_o[%0d]: got %h want cafef00d", i, wdata_o); end
      n_cmp++; if (wd_o !== 5'd3) begin n_err++; $display("FAIL stall_done wd_o[%0d]: got %0d want 3", i, wd_o); end
      n_cmp++; if ({stall_req_o, sram_bus.sram_ce_n_o} !== 2'b01) begin n_err++; $display("FAIL stall_done stall/ce_n[%0d]: got %b want 01", i, {stall_req_o, sram_bus.sram_ce_n_o}); end
    end
    $display("stall_done: held wdata=%h wd=%0d", wdata_o, wd_o);
    flush_i = 1'b1;
    step;
    flush_i = 1'b0;
    n_cmp++; if ({wd_o, wreg_o} !== 6'd0) begin n_err++; $display("FAIL flush_stall wd/wreg: got %0d/%b want 0/0", wd_o, wreg_o); end
    n_cmp++; if (wdata_o !== 32'h0) begin n_err++; $display("FAIL flush_stall wdata_o: got %h want 0", wdata_o); end
    $display("flush_stall: wreg=%b wdata=%h", wreg_o, wdata_o);
    stall_i = 1'b0;
    set_ex(4'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    step;
  endtask

  task automatic test_back_to_back;
    set_ex(4'd0, 5'd1, 1'b1, 32'h0000_000A, 32'h0, 32'h0);
    step;
    n_cmp++; if ({wd_o, wdata_o} !== {5'd1, 32'h0000_000A}) begin n_err++; $display("FAIL b2b first: got %0d/%h want 1/0000000a", wd_o, wdata_o); end
    set_ex(4'd9, 5'd2, 1'b1, 32'h0000_000B, 32'h0000_0004, 32'h0);
    step;
    n_cmp++; if ({wd_o, wdata_o} !== {5'd2, 32'h0000_000B}) begin n_err++; $display("FAIL b2b second: got %0d/%h want 2/0000000b", wd_o, wdata_o); end
    n_cmp++; if ({stall_req_o, sram_bus.sram_ce_n_o} !== 2'b01) begin n_err++; $display("FAIL b2b badop stall/ce_n: got %b want 01", {stall_req_o, sram_bus.sram_ce_n_o}); end
    $display("back_to_back: wd=%0d wdata=%h", wd_o, wdata_o);
    set_ex(4'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    step;
  endtask

`ifdef LSU_MISALIGN_EXC_EN
  task automatic test_misalign;
    set_ex(4'd5, 5'd4, 1'b1, 32'h0, 32'h0000_0102, 32'h0);
    step;
    set_ex(4'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    n_cmp++; if (misalign_o !== 1'b1) begin n_err++; $display("FAIL misalign pulse: got %b want 1", misalign_o); end
    n_cmp++; if (badvaddr_o !== 32'h0000_0102) begin n_err++; $display("FAIL misalign badvaddr: got %h want 00000102", badvaddr_o); end
    n_cmp++; if ({sram_bus.sram_ce_n_o, stall_req_o, wreg_o} !== 3'b100) begin n_err++; $display("FAIL misalign ce_n/stall/wreg: got %b want 100", {sram_bus.sram_ce_n_o, stall_req_o, wreg_o}); end
    step;
    n_cmp++; if (misalign_o !== 1'b0) begin n_err++; $display("FAIL misalign pulse end: got %b want 0", misalign_o); end
    $display("misalign: badvaddr=%h", badvaddr_o);
  endtask
`endif

  task automatic test_reset_mid_access;
    set_ex(4'd8, 5'd0, 1'b0, 32'h0, 32'h0000_0020, 32'h0102_0304);
    step;
    set_ex(4'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    step;
    n_cmp++; if (sram_bus.sram_we_n_o !== 1'b0) begin n_err++; $display("FAIL rst_mid pre we_n: got %b want 0", sram_bus.sram_we_n_o); end
    #2;
    rst_i = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    $display("reset_mid_access: we_n=%b ce_n=%b", sram_bus.sram_we_n_o, sram_bus.sram_ce_n_o);
    @(negedge clk_i);
    rst_i = 1'b1;
    step;
  endtask

  initial begin
    sram_bus.sram_data_i = 32'h0;
    test_reset;
    test_alu;
    test_load("lb",  4'd1, 32'h0000_0003, 32'h80FF_0000, 20'h0, 32'hFFFF_FF80);
    test_load("lbu", 4'd2, 32'h0000_0003, 32'h80FF_0000, 20'h0, 32'h0000_0080);
    test_load("lh",  4'd3, 32'h0000_0006, 32'h8001_1234, 20'h1, 32'hFFFF_8001);
    test_load("lhu", 4'd4, 32'h0000_0006, 32'h8001_1234, 20'h1, 32'h0000_8001);
    test_load("lw",  4'd5, 32'h0000_0008, 32'h1357_9BDF, 20'h2, 32'h1357_9BDF);
    test_store("sh", 4'd7, 32'h0000_0006, 32'hAAAA_BEEF, 20'h1, 32'hBEEF_BEEF, 4'b0011);
    test_store("sb", 4'd6, 32'h0000_0005, 32'h1234_5678, 20'h1, 32'h7878_7878, 4'b1101);
    test_store("sw", 4'd8, 32'h0000_000C, 32'hDEAD_BEEF, 20'h3, 32'hDEAD_BEEF, 4'b0000);
    test_stall_done;
    test_back_to_back;
`ifdef LSU_MISALIGN_EXC_EN
    test_misalign;
`endif
    test_reset_mid_access;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
